// File: rtl/hw_rng_coprime_seq_pkg.sv
// Shared types and helpers for the coprime candidate sequencer.
package hw_rng_pkg;

    // Per-channel sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_GNT  = 3'd1,
        ST_GCD_CALC  = 3'd2,
        ST_GCD_CHECK = 3'd3,
        ST_REGEN     = 3'd4
    } ch_state_e;

    // Default retry counter width.
    localparam int DEF_CNTW = 8;

    // Width of a channel index / round-robin pointer (at least one bit).
    function automatic int ptr_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hw_rng_coprime_seq_rr_arbiter.sv
// Round-robin arbiter: grants one requester while enabled, the search
// starts at the pointer, and the pointer moves to winner+1 on a grant.
module rr_arbiter
    import hw_rng_pkg::*;
#(
    parameter int N = 2
) (
    input  logic                 hclk,
    input  logic                 hresetn,
    input  logic                 en_i,
    input  logic [N-1:0]         req_i,
    output logic [N-1:0]         gnt_o,
    output logic [ptr_w(N)-1:0]  gnt_idx_o
);

    localparam int PW = ptr_w(N);

    logic [PW-1:0] ptr_q, ptr_d;
    logic          found;
    int            j;

    // Scan requesters starting at the pointer; first hit wins.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        ptr_d     = ptr_q;
        found     = 1'b0;
        j         = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_q) + k) % N;
            if (en_i && !found && req_i[j]) begin
                found     = 1'b1;
                gnt_o[j]  = 1'b1;
                gnt_idx_o = PW'(j);
            end
        end
        if (found)
            ptr_d = (gnt_idx_o == PW'(N - 1)) ? '0 : gnt_idx_o + 1'b1;
    end

    // Priority pointer register.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end

endmodule

// File: rtl/hw_rng_coprime_seq.sv
// Multi-channel odd-candidate sequencer sharing one extended-GCD engine.
// Each channel forces its RNG value odd, waits for the engine, and on a
// non-invertible result steps the candidate by +2 up to errcnt_max times.
module hw_rng_coprime_seq
    import hw_rng_pkg::*;
#(
    parameter int NBITS = 1024,
    parameter int NCH   = 2,
    parameter int CNTW  = DEF_CNTW
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  start,
    input  logic                  chain_en,
    input  logic [NCH-1:0]        rng_done,
    input  logic [NCH*NBITS-1:0]  rng_y,
    input  logic [CNTW-1:0]       errcnt_max,
    input  logic                  gcd_done,
    input  logic                  gcd_inverr,
    output logic                  gcd_start,
    output logic [NBITS-1:0]      gcd_operand,
    output logic [NCH-1:0]        rng_enable,
    output logic [NCH*NBITS-1:0]  rand_out,
    output logic [NCH-1:0]        rand_valid,
    output logic [NCH-1:0]        rand_fail,
    output logic                  busy
);

    localparam int PW = ptr_w(NCH);

    logic [NCH-1:0]            req, gnt, idle, done_ch, vld_nx;
    logic [PW-1:0]             gnt_idx;
    logic [NCH-1:0][NBITS-1:0] cand_all;
    logic [NCH-1:0]            unused_lsb;

    logic          owner_vld_q, owner_vld_d;
    logic [PW-1:0] owner_q, owner_d;
    logic          gcd_start_q, gcd_start_d;
    logic [NCH-1:0] rng_en_q, rng_en_d;

    // Grants are only issued while the engine has no owner, so a channel
    // freeing the engine cannot be re-granted in the same cycle.
    rr_arbiter #(.N(NCH)) u_arb (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .en_i      (~owner_vld_q),
        .req_i     (req),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    // Engine ownership: taken on grant, released on gcd_done.
    always_comb begin
        owner_vld_d = owner_vld_q;
        owner_d     = owner_q;
        gcd_start_d = |gnt;
        if (!owner_vld_q && |gnt) begin
            owner_vld_d = 1'b1;
            owner_d     = gnt_idx;
        end else if (owner_vld_q && gcd_done) begin
            owner_vld_d = 1'b0;
        end
    end

    // RNG enables: start kicks channel 0; a success optionally kicks the next.
    always_comb begin
        rng_en_d    = '0;
        rng_en_d[0] = start;
        if (chain_en)
            for (int i = 1; i < NCH; i++) rng_en_d[i] = vld_nx[i-1];
    end

    // Shared-engine and enable registers.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            owner_vld_q <= 1'b0;
            owner_q     <= '0;
            gcd_start_q <= 1'b0;
            rng_en_q    <= '0;
        end else begin
            owner_vld_q <= owner_vld_d;
            owner_q     <= owner_d;
            gcd_start_q <= gcd_start_d;
            rng_en_q    <= rng_en_d;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        ch_state_e        st_q, st_d;
        logic [NBITS-1:0] cand_q, cand_d, rout_q, rout_d;
        logic [CNTW-1:0]  cnt_q, cnt_d;
        logic             inv_q, inv_d, vld_q, vld_d, fail_q, fail_d;

        assign done_ch[i] = gcd_done && owner_vld_q && (owner_q == PW'(i));

        // Channel next-state: latch, arbitrate, compute, check, regenerate.
        always_comb begin
            st_d   = st_q;
            cand_d = cand_q;
            cnt_d  = cnt_q;
            inv_d  = inv_q;
            rout_d = rout_q;
            vld_d  = 1'b0;
            fail_d = 1'b0;
            case (st_q)
                ST_IDLE: if (rng_done[i]) begin
                    cand_d = {rng_y[i*NBITS+1 +: NBITS-1], 1'b1};
                    cnt_d  = '0;
                    st_d   = ST_WAIT_GNT;
                end
                ST_WAIT_GNT: if (gnt[i]) st_d = ST_GCD_CALC;
                ST_GCD_CALC: if (done_ch[i]) begin
                    inv_d = gcd_inverr;
                    st_d  = ST_GCD_CHECK;
                end
                ST_GCD_CHECK: begin
                    if (!inv_q) begin
                        rout_d = cand_q;
                        vld_d  = 1'b1;
                        st_d   = ST_IDLE;
                    end else if (cnt_q >= errcnt_max) begin
                        fail_d = 1'b1;
                        st_d   = ST_IDLE;
                    end else begin
                        st_d = ST_REGEN;
                    end
                end
                ST_REGEN: begin
                    // Adding 2 to an odd value keeps it odd, including on wrap.
                    cand_d = cand_q + NBITS'(2);
                    cnt_d  = cnt_q + 1'b1;
                    st_d   = ST_WAIT_GNT;
                end
                default: st_d = ST_IDLE;
            endcase
        end

        // Channel state registers.
        always_ff @(posedge hclk or negedge hresetn) begin
            if (!hresetn) begin
                st_q   <= ST_IDLE;
                cand_q <= '0;
                cnt_q  <= '0;
                inv_q  <= 1'b0;
                rout_q <= '0;
                vld_q  <= 1'b0;
                fail_q <= 1'b0;
            end else begin
                st_q   <= st_d;
                cand_q <= cand_d;
                cnt_q  <= cnt_d;
                inv_q  <= inv_d;
                rout_q <= rout_d;
                vld_q  <= vld_d;
                fail_q <= fail_d;
            end
        end

        assign req[i]                     = (st_q == ST_WAIT_GNT);
        assign idle[i]                    = (st_q == ST_IDLE);
        assign cand_all[i]                = cand_q;
        assign vld_nx[i]                  = vld_d;
        assign unused_lsb[i]              = rng_y[i*NBITS];
        assign rand_out[i*NBITS +: NBITS] = rout_q;
        assign rand_valid[i]              = vld_q;
        assign rand_fail[i]               = fail_q;
    end

    assign gcd_start   = gcd_start_q;
    assign gcd_operand = owner_vld_q ? cand_all[owner_q] : '0;
    assign rng_enable  = rng_en_q;
    assign busy        = ~&idle;

endmodule

// File: tb/tb_hw_rng_coprime_seq.sv
// Randomized bench for hw_rng_coprime_seq; the bench plays the GCD engine
// and predicts operands, grant order, outcomes and timing arithmetically.
module tb_hw_rng_coprime_seq;

    localparam int NBITS = 32;
    localparam int NCH   = 2;
    localparam int CNTW  = 8;

    logic                 hclk = 1'b0, hresetn = 1'b1, start = 1'b0, chain_en = 1'b0;
    logic [NCH-1:0]       rng_done = '0;
    logic [NCH*NBITS-1:0] rng_y = '0;
    logic [CNTW-1:0]      errcnt_max = '0;
    logic                 gcd_done = 1'b0, gcd_inverr = 1'b0;
    logic                 gcd_start, busy;
    logic [NBITS-1:0]     gcd_operand;
    logic [NCH-1:0]       rng_enable, rand_valid, rand_fail;
    logic [NCH*NBITS-1:0] rand_out;

    int n_chk = 0, n_err = 0;

    // Reference model state.
    logic [NBITS-1:0]     m_cand [NCH];
    int                   m_cnt  [NCH];
    bit                   m_act  [NCH];
    logic [NCH*NBITS-1:0] m_out;
    int                   m_ptr;

    hw_rng_coprime_seq #(.NBITS(NBITS), .NCH(NCH), .CNTW(CNTW)) dut (
        .hclk(hclk), .hresetn(hresetn), .start(start), .chain_en(chain_en),
        .rng_done(rng_done), .rng_y(rng_y), .errcnt_max(errcnt_max),
        .gcd_done(gcd_done), .gcd_inverr(gcd_inverr), .gcd_start(gcd_start),
        .gcd_operand(gcd_operand), .rng_enable(rng_enable), .rand_out(rand_out),
        .rand_valid(rand_valid), .rand_fail(rand_fail), .busy(busy)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge hclk);
        @(negedge hclk);
    endtask

    task automatic launch(input int c, input logic [NBITS-1:0] y);
        rng_y[c*NBITS +: NBITS] = y;
        rng_done[c] = 1'b1;
        step();
        rng_done = '0;
    endtask

    task automatic gdone(input bit inv);
        gcd_done = 1'b1;
        gcd_inverr = inv;
        step();
        gcd_done = 1'b0;
        gcd_inverr = 1'b0;
    endtask

    task automatic wait_gs(output int lat, input int lat0);
        lat = lat0;
        while (gcd_start !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_start"}, gcd_start, 0);
        chk({tag, "_oper"},  gcd_operand, 0);
        chk({tag, "_en"},    rng_enable, 0);
        chk({tag, "_out"},   rand_out, 0);
        chk({tag, "_vld"},   rand_valid, 0);
        chk({tag, "_fail"},  rand_fail, 0);
        chk({tag, "_busy"},  busy, 0);
    endtask

    task automatic do_reset();
        @(negedge hclk);
        hresetn = 1'b0;
        @(negedge hclk);
        hresetn = 1'b1;
        m_out = '0;
        m_ptr = 0;
        for (int c = 0; c < NCH; c++) m_act[c] = 1'b0;
    endtask

    // One randomized round: a random set of channels starts together and is
    // served until every channel succeeds or exhausts its retries.
    task automatic rand_round();
        logic [NCH-1:0]   mask, exp_v, exp_f, exp_en;
        logic [NBITS-1:0] y;
        int w, lat, last, lat0, iter;
        bit inv, any;
        mask = NCH'($urandom_range(1, (1 << NCH) - 1));
        errcnt_max = CNTW'($urandom_range(0, 3));
        chain_en = 1'($urandom_range(0, 1));
        for (int c = 0; c < NCH; c++)
            if (mask[c]) begin
                y = $urandom;
                rng_y[c*NBITS +: NBITS] = y;
                m_cand[c] = {y[NBITS-1:1], 1'b1};
                m_cnt[c] = 0;
                m_act[c] = 1'b1;
            end
        rng_done = mask;
        step();
        rng_done = '0;
        last = -1; lat0 = 1; iter = 0;
        any = 1'b1;
        while (any && iter < 40) begin
            iter++;
            w = -1;
            for (int k = 0; k < NCH; k++)
                if (w < 0 && m_act[(m_ptr + k) % NCH] && ((m_ptr + k) % NCH) != last)
                    w = (m_ptr + k) % NCH;
            if (w < 0) w = last;
            m_ptr = (w + 1) % NCH;
            wait_gs(lat, lat0);
            chk("rnd_lat", lat, (last >= 0 && w == last) ? 4 : 2);
            chk("rnd_oper", gcd_operand, m_cand[w]);
            repeat ($urandom_range(0, 3)) step();
            chk("rnd_oper_hold", gcd_operand, m_cand[w]);
            inv = 1'($urandom_range(0, 1));
            gdone(inv);
            chk("rnd_early", rand_valid | rand_fail, 0);
            step();
            exp_v = '0; exp_f = '0; exp_en = '0;
            if (!inv) begin
                exp_v[w] = 1'b1;
                m_out[w*NBITS +: NBITS] = m_cand[w];
                m_act[w] = 1'b0;
                if (chain_en && w < NCH - 1) exp_en[w+1] = 1'b1;
            end else if (m_cnt[w] == int'(errcnt_max)) begin
                exp_f[w] = 1'b1;
                m_act[w] = 1'b0;
            end else begin
                m_cnt[w]++;
                m_cand[w] = m_cand[w] + NBITS'(2);
            end
            chk("rnd_vld", rand_valid, exp_v);
            chk("rnd_fail", rand_fail, exp_f);
            chk("rnd_out", rand_out, m_out);
            chk("rnd_en", rng_enable, exp_en);
            last = w; lat0 = 2;
            any = 1'b0;
            for (int c = 0; c < NCH; c++) any |= m_act[c];
        end
        chk("rnd_done_bound", any, 0);
        step();
        chk("rnd_busy", busy, 0);
        chk("rnd_oper_idle", gcd_operand, 0);
    endtask

    initial begin
        logic [NBITS-1:0] y, c0, c1, prev;
        int lat;
        #2 hresetn = 1'b0;
        @(negedge hclk);
        chk_all_zero("rst");
        @(negedge hclk);
        hresetn = 1'b1;
        m_out = '0; m_ptr = 0;
        for (int c = 0; c < NCH; c++) m_act[c] = 1'b0;

        // Even RNG value is forced odd; success two cycles after gcd_done.
        errcnt_max = '0;
        y = $urandom; y[7:0] = 8'h10;
        c0 = {y[NBITS-1:1], 1'b1};
        launch(0, y);
        chk("t1_busy", busy, 1);
        chk("t1_nostart", gcd_start, 0);
        step();
        chk("t1_start", gcd_start, 1);
        chk("t1_oper", gcd_operand, c0);
        launch(0, ~y);
        chk("t1_pulse", gcd_start, 0);
        chk("t1_ignored", gcd_operand, c0);
        gdone(1'b0);
        chk("t1_vld_early", rand_valid, 0);
        step();
        chk("t1_vld", rand_valid, 2'b01);
        chk("t1_out", rand_out[NBITS-1:0], c0);
        step();
        chk("t1_vld_pulse", rand_valid, 0);
        chk("t1_idle", busy, 0);

        // Three non-invertible results with errcnt_max=2 end in failure.
        prev = c0;
        errcnt_max = 8'd2;
        y = $urandom;
        c1 = {y[NBITS-1:1], 1'b1};
        launch(0, y);
        wait_gs(lat, 1);
        chk("t2_lat", lat, 2);
        for (int a = 0; a < 3; a++) begin
            chk("t2_oper", gcd_operand, c1 + NBITS'(2 * a));
            gdone(1'b1);
            step();
            if (a < 2) begin
                chk("t2_nofail", rand_fail, 0);
                wait_gs(lat, 2);
                chk("t2_retry_lat", lat, 4);
            end
        end
        chk("t2_fail", rand_fail, 2'b01);
        chk("t2_novld", rand_valid, 0);
        chk("t2_held", rand_out[NBITS-1:0], prev);

        // All-ones candidate wraps to 1 on regeneration.
        errcnt_max = 8'd1;
        launch(0, '1);
        wait_gs(lat, 1);
        chk("t3_oper", gcd_operand, {NBITS{1'b1}});
        gdone(1'b1);
        step();
        wait_gs(lat, 2);
        chk("t3_wrap", gcd_operand, 1);
        gdone(1'b0);
        step();
        chk("t3_vld", rand_valid, 2'b01);
        chk("t3_out", rand_out[NBITS-1:0], 1);

        // Start and chained enables.
        errcnt_max = '0;
        chain_en = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t4_en0", rng_enable, 2'b01);
        step();
        chk("t4_en0_pulse", rng_enable, 0);
        launch(0, $urandom);
        wait_gs(lat, 1);
        gdone(1'b0);
        step();
        chk("t4_chain", rng_enable, 2'b10);
        chain_en = 1'b0;
        launch(0, $urandom);
        wait_gs(lat, 1);
        gdone(1'b0);
        step();
        chk("t4_vld", rand_valid, 2'b01);
        chk("t4_nochain", rng_enable, 0);

        // Simultaneous requests after reset: channel 0 first, then channel 1.
        do_reset();
        y = $urandom; c0 = {y[NBITS-1:1], 1'b1}; rng_y[0 +: NBITS] = y;
        y = $urandom; c1 = {y[NBITS-1:1], 1'b1}; rng_y[NBITS +: NBITS] = y;
        rng_done = 2'b11;
        step();
        rng_done = '0;
        wait_gs(lat, 1);
        chk("t5_lat", lat, 2);
        chk("t5_oper0", gcd_operand, c0);
        gdone(1'b0);
        chk("t5_no_regrant", gcd_start, 0);
        step();
        chk("t5_start1", gcd_start, 1);
        chk("t5_oper1", gcd_operand, c1);
        chk("t5_vld0", rand_valid, 2'b01);
        gdone(1'b0);
        step();
        chk("t5_vld1", rand_valid, 2'b10);
        chk("t5_out", rand_out, {c1, c0});

        // Reset during GCD_CALC, then a stray gcd_done.
        launch(0, $urandom);
        step();
        hresetn = 1'b0;
        #1;
        chk_all_zero("t6_rst");
        @(negedge hclk);
        hresetn = 1'b1;
        gdone(1'b0);
        for (int k = 0; k < 4; k++) begin
            chk("t6_quiet", {gcd_start, rand_valid, rand_fail, busy}, 0);
            step();
        end
        m_out = '0; m_ptr = 0;
        for (int c = 0; c < NCH; c++) m_act[c] = 1'b0;

        for (int r = 0; r < 30; r++) rand_round();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_err);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hw_rng_coprime_seq.md
# hw_rng_coprime_seq

Multi-channel sequencer that turns raw RNG outputs into odd candidates coprime with the modulus, sharing one binary extended-GCD engine across NCH channels. Each channel latches an odd candidate, queues for the GCD engine, and on a non-invertible result steps the candidate by +2 and retries, up to a programmable limit. It sits in gpcfg between the RNG instances, the shared bin_ext_gcd engine and the hardware random-number registers, and optionally chains RNG enables channel to channel.

## Interface
- NBITS, 1024, candidate / GCD operand width
- NCH, 2, channel count (1..8)
- CNTW, 8, retry counter width
- hclk  in  1  clock
- hresetn  in  1  asynchronous, active-low reset
- start  in  1  pulse; fires rng_enable[0]
- chain_en  in  1  1: channel i success fires rng_enable[i+1]
- rng_done  in  NCH  per-channel RNG done pulse
- rng_y  in  NCH*NBITS  raw RNG values; channel i at [i*NBITS +: NBITS]
- errcnt_max  in  CNTW  regenerations allowed per candidate
- gcd_done  in  1  GCD engine done pulse
- gcd_inverr  in  1  valid with gcd_done; 1 = not coprime
- gcd_start  out  1  one-cycle GCD launch pulse
- gcd_operand  out  NBITS  candidate of the channel owning the engine
- rng_enable  out  NCH  one-cycle RNG enable pulses
- rand_out  out  NCH*NBITS  accepted candidates, held
- rand_valid  out  NCH  one-cycle success pulse per channel
- rand_fail  out  NCH  one-cycle pulse: retries exhausted
- busy  out  1  any channel not IDLE

## Operation
- Per-channel states: IDLE, WAIT_GNT, GCD_CALC, GCD_CHECK, REGEN.
- IDLE: rng_done[i] -> cand[i] <= {rng_y_i[NBITS-1:1],1'b1}, cnt[i] <= 0, -> WAIT_GNT. rng_done[i] in any other state is ignored.
- WAIT_GNT: round-robin arbiter among WAIT_GNT channels, evaluated only while engine free; priority pointer moves to winner+1. Winner -> GCD_CALC, owner <= i, gcd_start pulsed.
- GCD_CALC: gcd_done -> latch gcd_inverr, free engine, -> GCD_CHECK. gcd_done with no owner is ignored.
- GCD_CHECK: inverr=0 -> rand_out[i] <= cand[i], rand_valid[i] pulse, IDLE. inverr=1 and cnt[i]==errcnt_max -> rand_fail[i] pulse, rand_out unchanged, IDLE. Else -> REGEN.
- REGEN: cand[i] <= cand[i]+2 mod 2^NBITS (wrap keeps LSB 1), cnt[i] <= cnt[i]+1, -> WAIT_GNT.
- errcnt_max=0: first inverr fails. Counter never exceeds errcnt_max.
- rng_enable[0] pulses the cycle after start. chain_en=1: rand_valid[i] also pulses rng_enable[i+1] (i<NCH-1) in the same cycle; rand_fail does not chain.
- gcd_operand = cand[owner], stable from gcd_start through gcd_done; 0 when no owner.

## Timing
- Reset: all states IDLE, cand/rand_out/cnt 0, owner none, pointer 0; every output 0.
- rng_done at cycle t, engine free, no contention: WAIT_GNT at t+1, gcd_start at t+2 (GCD_CALC).
- gcd_done at cycle u: GCD_CHECK at u+1; rand_valid/rand_fail at u+2, or REGEN at u+2 and gcd_start again at u+4 if uncontended.
- Engine freed by gcd_done at u: a waiting channel may receive gcd_start at u+2 earliest (no same-cycle re-grant).
- Simultaneous rng_done on several channels: all latch; grants serialised by round-robin.
- Reset mid-operation: immediate return to reset values; in-flight GCD result afterwards ignored (no owner).

## Structure
- Package hw_rng_pkg: state encodings (3-bit), arbiter pointer width function, default CNTW.
- Sub-module rr_arbiter (NCH request/grant, pointer register); remainder is a generate loop of per-channel FSMs plus owner mux.

## Test plan
- NCH=2, rng_done[0] with y=0x...10 (even), inverr=0 -> gcd_operand ...11, rand_valid[0] at u+2, rand_out[0]=...11.
- errcnt_max=2, inverr=1 three times -> operands c, c+2, c+4; rand_fail[0], rand_out unchanged, cnt stops at 2.
- rng_done[0], rng_done[1] same cycle -> channel 0 granted first, channel 1 after gcd_done, second grant next at u+2; both rand_valid.
- cand = all-ones, inverr=1 -> next operand 0x...01 (wrap), LSB 1.
- chain_en=1, start -> rng_enable[0]; rand_valid[0] -> rng_enable[1] same cycle; chain_en=0 -> no rng_enable[1].
- hresetn low during GCD_CALC, then stray gcd_done -> all outputs 0, no valid/fail, busy 0.
